plab2_proc_mem_arbiter: RTL and testbench
=========================================

Name: plab2_proc_mem_arbiter

Overview:
- Shares one memory request/response port pair between two requesters: port 0 is the instruction side, port 1 is the data side.
- Sits between the pipelined processor's imem/dmem ports and a single-ported test memory or cache.
- Arbitrates requests round-robin.
- Records each grant in an in-order ID FIFO and uses it to steer every memory response back to the requester that issued it.
- Message contents, including the opaque field, pass through unmodified.

Parameters:
- p_req_nbits, 77, request message width (VC_MEM_REQ_MSG_NBITS(8,32,32)).
- p_resp_nbits, 45, response message width (VC_MEM_RESP_MSG_NBITS(8,32)).
- p_max_outstanding, 4, maximum in-flight requests; ID FIFO depth; power of two, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- in0_req_msg  in  p_req_nbits  requester 0 (imem) request
- in0_req_val  in  1
- in0_req_rdy  out  1
- in0_resp_msg  out  p_resp_nbits  response to requester 0
- in0_resp_val  out  1
- in0_resp_rdy  in  1
- in1_req_msg / in1_req_val / in1_req_rdy  same as port 0, requester 1 (dmem)
- in1_resp_msg / in1_resp_val / in1_resp_rdy  same as port 0, requester 1
- memreq_msg  out  p_req_nbits  shared memory request
- memreq_val  out  1
- memreq_rdy  in  1
- memresp_msg  in  p_resp_nbits  shared memory response
- memresp_val  in  1
- memresp_rdy  out  1

Behaviour:
- State:
  - prio: 1 bit, requester with priority; reset 0.
  - ID FIFO: p_max_outstanding × 1 bit, with head/tail pointers of clog2(depth) bits.
  - count: clog2(depth)+1 bits; reset 0.
  - Reset is asynchronous: all state clears immediately when reset goes low, regardless of clk.
- can_issue = (count < p_max_outstanding).
- Grant (combinational):
  - If can_issue and only one requester has val high, that requester is granted.
  - If both are high, the requester equal to prio is granted.
  - If !can_issue, nothing is granted.
- memreq_val = can_issue & (in0_req_val | in1_req_val).
- memreq_msg = granted requester's msg, or in0_req_msg when neither is granted.
- inX_req_rdy = grantX & memreq_rdy. A non-granted requester sees rdy=0.
- rdy never depends on the same requester's own val beyond the grant decision. No combinational path from memresp_* to any *_req_rdy.
- Request fire (memreq_val & memreq_rdy):
  - Push the granted ID at tail; tail wraps modulo depth.
  - Set prio to the opposite of the granted ID. Prio changes only on fire, not while stalled.
- Response routing:
  - head_id = FIFO[head].
  - in{head_id}_resp_val = memresp_val & (count != 0). The other port's resp_val = 0.
  - Both inX_resp_msg = memresp_msg (data is don't-care on the invalid port).
  - memresp_rdy = (count != 0) & in{head_id}_resp_rdy.
- Response fire (memresp_val & memresp_rdy): pop head; head wraps modulo depth.
- Count update:
  - Push only: count+1.
  - Pop only: count−1.
  - Push and pop in the same cycle: count unchanged, both pointers advance.
  - At count == p_max_outstanding with a pop in the same cycle, a push is NOT allowed (can_issue uses registered count).
- Empty (count == 0): memresp_rdy = 0 and both resp_val = 0. A spurious memresp is back-pressured indefinitely.
- Memory must return responses in request order. Out-of-order memory is unsupported.
- Zero added latency on both paths: request and response traverse combinationally in the fire cycle.
- Reset mid-operation: all in-flight IDs are discarded and count/prio return to 0. The environment must also reset the memory.
- Outputs during reset: memreq_val = 0, memresp_rdy = 0, all resp_val = 0, all req_rdy = 0.

Test Plan:
1. Only in0 valid, addr 0x1000, memreq_rdy=1 → in0_req_rdy=1 same cycle; memreq_msg = in0 msg; response data 0xCAFE → in0_resp_val=1, in1_resp_val=0.
2. Both valid continuously, memreq_rdy=1 → grants alternate 0,1,0,1 starting with 0 after reset; responses route in the same order.
3. Issue 4 requests with memory holding all responses → 5th request stalls (memreq_val=0, both req_rdy=0). Release one response → next cycle the request issues.
4. Simultaneous fire of a new request and a response at count=2 → count stays 2, correct routing; pointer wrap exercised over 10 transactions.
5. in1_resp_rdy=0 while head_id=1 and memresp_val=1 → memresp_rdy=0 and the FIFO holds. Raise rdy → delivered to in1 only.
6. Assert reset low asynchronously mid-burst (3 outstanding) → memreq_val=0 and memresp_rdy=0 immediately. After release, the first grant goes to in0 and count is 0.

Source files
------------

// File: rtl/plab2_proc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// plab2_proc_mem_arbiter
//
// Shares one memory request/response port pair between the processor's
// instruction side (port 0) and data side (port 1). Requests are arbitrated
// round-robin and forwarded combinationally. The ID of every accepted request
// is pushed into a small in-order FIFO. Each memory response is steered back
// to the requester at the head of that FIFO. Messages, including the opaque
// field, pass through untouched.
//
// Ports
//   clk, reset             clock; asynchronous active-low reset
//   in0_req_* / in0_resp_* requester 0 (imem) request in, response out
//   in1_req_* / in1_resp_* requester 1 (dmem) request in, response out
//   memreq_*               shared request towards memory
//   memresp_*              shared response from memory
//
// Handshake: a message transfers on a clock edge where both val and rdy are
// high. A producer may raise val without waiting for rdy. This block never
// lets a req_rdy depend on anything in memresp_*. A requester's req_rdy depends
// on its own val only through the grant decision.
//
// Memory must return responses in request order. At most p_max_outstanding
// requests may be in flight. p_max_outstanding must be a power of two and at
// least 2, so the FIFO pointers wrap naturally.
// ---------------------------------------------------------------------------
module plab2_proc_mem_arbiter #(
  parameter int p_req_nbits       = 77,
  parameter int p_resp_nbits      = 45,
  parameter int p_max_outstanding = 4
) (
  input  logic                    clk,
  input  logic                    reset,

  input  logic [p_req_nbits-1:0]  in0_req_msg,
  input  logic                    in0_req_val,
  output logic                    in0_req_rdy,
  output logic [p_resp_nbits-1:0] in0_resp_msg,
  output logic                    in0_resp_val,
  input  logic                    in0_resp_rdy,

  input  logic [p_req_nbits-1:0]  in1_req_msg,
  input  logic                    in1_req_val,
  output logic                    in1_req_rdy,
  output logic [p_resp_nbits-1:0] in1_resp_msg,
  output logic                    in1_resp_val,
  input  logic                    in1_resp_rdy,

  output logic [p_req_nbits-1:0]  memreq_msg,
  output logic                    memreq_val,
  input  logic                    memreq_rdy,

  input  logic [p_resp_nbits-1:0] memresp_msg,
  input  logic                    memresp_val,
  output logic                    memresp_rdy
);

  localparam int ptr_nbits = $clog2(p_max_outstanding);
  localparam int cnt_nbits = ptr_nbits + 1;

  localparam logic [cnt_nbits-1:0] max_count = cnt_nbits'(p_max_outstanding);
  localparam logic [cnt_nbits-1:0] cnt_one   = cnt_nbits'(1);
  localparam logic [ptr_nbits-1:0] ptr_one   = ptr_nbits'(1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  logic                         prio;     // requester that wins a tie
  logic [p_max_outstanding-1:0] id_fifo;  // requester ID of each in-flight request
  logic [ptr_nbits-1:0]         head;
  logic [ptr_nbits-1:0]         tail;
  logic [cnt_nbits-1:0]         count;

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  logic can_issue;
  logic grant0;
  logic grant1;
  logic req_fire;
  logic req_id;

  // can_issue uses the registered count. A pop in this cycle therefore does
  // not open a slot until the next cycle. Holding reset low also blocks
  // issue, so memreq_val and every req_rdy are low while reset is asserted.
  assign can_issue = reset & (count < max_count);

  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (can_issue) begin
      if (in0_req_val && in1_req_val) begin
        grant0 = (prio == 1'b0);
        grant1 = (prio == 1'b1);
      end else begin
        grant0 = in0_req_val;
        grant1 = in1_req_val;
      end
    end
  end

  assign memreq_val  = grant0 | grant1;
  assign memreq_msg  = grant1 ? in1_req_msg : in0_req_msg;
  assign in0_req_rdy = grant0 & memreq_rdy;
  assign in1_req_rdy = grant1 & memreq_rdy;

  assign req_fire = memreq_val & memreq_rdy;
  assign req_id   = grant1;

  // -------------------------------------------------------------------------
  // Response side
  // -------------------------------------------------------------------------
  logic not_empty;
  logic head_id;
  logic resp_fire;

  assign not_empty = (count != '0);
  assign head_id   = id_fifo[head];

  // With nothing in flight, both resp_val outputs and memresp_rdy stay low.
  // A spurious memory response therefore waits until something is issued.
  assign in0_resp_val = memresp_val & not_empty & ~head_id;
  assign in1_resp_val = memresp_val & not_empty &  head_id;
  assign in0_resp_msg = memresp_msg;
  assign in1_resp_msg = memresp_msg;
  assign memresp_rdy  = not_empty & (head_id ? in1_resp_rdy : in0_resp_rdy);

  assign resp_fire = memresp_val & memresp_rdy;

  // -------------------------------------------------------------------------
  // Priority: flips to the other requester after every accepted request.
  // A stalled request leaves priority unchanged.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prio <= 1'b0;
    end else if (req_fire) begin
      prio <= ~req_id;
    end
  end

  // -------------------------------------------------------------------------
  // ID FIFO storage and pointers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      id_fifo <= '0;
      tail    <= '0;
    end else if (req_fire) begin
      id_fifo[tail] <= req_id;
      tail          <= tail + ptr_one;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
    end else if (resp_fire) begin
      head <= head + ptr_one;
    end
  end

  // When a push and a pop happen together, the count is unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else begin
      case ({req_fire, resp_fire})
        2'b10:   count <= count + cnt_one;
        2'b01:   count <= count - cnt_one;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_plab2_proc_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for plab2_proc_mem_arbiter.
//
// A reference model runs on every falling edge. Its state is a queue of
// outstanding requester IDs and a priority bit. From that state and the
// current inputs it derives the required outputs, then advances on the fires
// it predicts. In random mode a behavioural memory answers requests in order.
// Per-requester expected queues then check end-to-end delivery. Directed
// scenarios add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_plab2_proc_mem_arbiter;

  localparam int RW = 77;
  localparam int SW = 45;
  localparam int D  = 4;

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [RW-1:0] in0_req_msg, in1_req_msg, memreq_msg;
  logic          in0_req_val, in1_req_val, in0_req_rdy, in1_req_rdy;
  logic [SW-1:0] in0_resp_msg, in1_resp_msg, memresp_msg;
  logic          in0_resp_val, in1_resp_val, in0_resp_rdy, in1_resp_rdy;
  logic          memreq_val, memreq_rdy, memresp_val, memresp_rdy;

  plab2_proc_mem_arbiter #(
    .p_req_nbits      (RW),
    .p_resp_nbits     (SW),
    .p_max_outstanding(D)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in0_req_msg (in0_req_msg),
    .in0_req_val (in0_req_val),
    .in0_req_rdy (in0_req_rdy),
    .in0_resp_msg(in0_resp_msg),
    .in0_resp_val(in0_resp_val),
    .in0_resp_rdy(in0_resp_rdy),
    .in1_req_msg (in1_req_msg),
    .in1_req_val (in1_req_val),
    .in1_req_rdy (in1_req_rdy),
    .in1_resp_msg(in1_resp_msg),
    .in1_resp_val(in1_resp_val),
    .in1_resp_rdy(in1_resp_rdy),
    .memreq_msg  (memreq_msg),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memresp_msg (memresp_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy)
  );

  // -------------------------------------------------------------------------
  // Scoreboard state
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  int            model_ids[$];   // requester IDs still in flight, oldest first
  logic          model_prio;
  logic [RW-1:0] mem_q[$];       // behavioural memory: accepted requests
  logic [SW-1:0] exp_q0[$];      // responses requester 0 must receive, in order
  logic [SW-1:0] exp_q1[$];
  logic          auto_mode = 1'b0;
  logic          fired0 = 1'b0;
  logic          fired1 = 1'b0;
  logic [15:0]   tag = 16'd0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Response the behavioural memory returns for a given request
  function automatic logic [SW-1:0] mem_answer(input logic [RW-1:0] req);
    return req[SW-1:0] ^ 45'h15A5A5A5A5A;
  endfunction

  function automatic logic [RW-1:0] new_msg(input logic id);
    logic [95:0] r;
    logic [RW-1:0] m;
    r = {$urandom(), $urandom(), $urandom()};
    m = r[RW-1:0];
    m[15:0] = tag;
    m[16]   = id;
    tag = tag + 16'd1;
    return m;
  endfunction

  // -------------------------------------------------------------------------
  // Compare process: reference model checked on every falling edge
  // -------------------------------------------------------------------------
  always @(negedge clk) begin
    logic g0, g1, can, e_mr, rf, sf;
    int hid;
    if (!reset) begin
      chk("rst_memreq_val", memreq_val, 0);
      chk("rst_memresp_rdy", memresp_rdy, 0);
      chk("rst_req_rdy", {in0_req_rdy, in1_req_rdy}, 0);
      chk("rst_resp_val", {in0_resp_val, in1_resp_val}, 0);
      model_ids.delete();
      model_prio = 1'b0;
      mem_q.delete();
      exp_q0.delete();
      exp_q1.delete();
      fired0 = 1'b0;
      fired1 = 1'b0;
    end else begin
      can = (model_ids.size() < D);
      g0  = can && in0_req_val && (!in1_req_val || model_prio == 1'b0);
      g1  = can && in1_req_val && (!in0_req_val || model_prio == 1'b1);
      chk("memreq_val", memreq_val, g0 | g1);
      chk("memreq_msg", memreq_msg, g1 ? in1_req_msg : in0_req_msg);
      chk("in0_req_rdy", in0_req_rdy, g0 & memreq_rdy);
      chk("in1_req_rdy", in1_req_rdy, g1 & memreq_rdy);

      hid  = (model_ids.size() != 0) ? model_ids[0] : -1;
      e_mr = (hid == 0 && in0_resp_rdy) || (hid == 1 && in1_resp_rdy);
      chk("in0_resp_val", in0_resp_val, memresp_val && hid == 0);
      chk("in1_resp_val", in1_resp_val, memresp_val && hid == 1);
      chk("memresp_rdy", memresp_rdy, e_mr);
      chk("in0_resp_msg", in0_resp_msg, memresp_msg);
      chk("in1_resp_msg", in1_resp_msg, memresp_msg);

      rf = (g0 | g1) && memreq_rdy;
      sf = memresp_val && e_mr;
      fired0 = g0 && memreq_rdy;
      fired1 = g1 && memreq_rdy;

      if (sf) begin
        if (auto_mode) begin
          if (hid == 0) begin
            if (exp_q0.size() != 0) chk("deliver0", in0_resp_msg, exp_q0.pop_front());
            else chk("deliver0_unexpected", 1, 0);
          end else begin
            if (exp_q1.size() != 0) chk("deliver1", in1_resp_msg, exp_q1.pop_front());
            else chk("deliver1_unexpected", 1, 0);
          end
          if (mem_q.size() != 0) void'(mem_q.pop_front());
        end
        void'(model_ids.pop_front());
      end
      if (rf) begin
        model_ids.push_back(g1 ? 1 : 0);
        model_prio = ~g1;
        if (auto_mode) begin
          mem_q.push_back(g1 ? in1_req_msg : in0_req_msg);
          if (g1) exp_q1.push_back(mem_answer(in1_req_msg));
          else    exp_q0.push_back(mem_answer(in0_req_msg));
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in0_req_val  = 1'b0; in0_req_msg = '0; in0_resp_rdy = 1'b0;
    in1_req_val  = 1'b0; in1_req_msg = '0; in1_resp_rdy = 1'b0;
    memreq_rdy   = 1'b0;
    memresp_val  = 1'b0; memresp_msg = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    idle_inputs();
    repeat (2) cyc();
    reset = 1'b1;
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      cyc();
      if (fired0 || !in0_req_val) begin
        in0_req_val = ($urandom_range(0, 3) != 0);
        in0_req_msg = new_msg(1'b0);
      end
      if (fired1 || !in1_req_val) begin
        in1_req_val = ($urandom_range(0, 3) != 0);
        in1_req_msg = new_msg(1'b1);
      end
      memreq_rdy   = ($urandom_range(0, 3) != 0);
      in0_resp_rdy = ($urandom_range(0, 3) != 0);
      in1_resp_rdy = ($urandom_range(0, 3) != 0);
      if (mem_q.size() != 0 && $urandom_range(0, 2) != 0) begin
        memresp_val = 1'b1;
        memresp_msg = mem_answer(mem_q[0]);
      end else begin
        memresp_val = 1'b0;
        memresp_msg = SW'({$urandom(), $urandom()});
      end
    end
  endtask

  task automatic drain();
    int budget;
    budget = 200;
    while (mem_q.size() != 0 && budget > 0) begin
      cyc();
      in0_req_val = 1'b0; in1_req_val = 1'b0;
      in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
      memresp_val = (mem_q.size() != 0);
      memresp_msg = (mem_q.size() != 0) ? mem_answer(mem_q[0]) : '0;
      budget--;
    end
    chk("drain_mem_q_empty", mem_q.size(), 0);
    cyc();
    memresp_val = 1'b0;
    #1;
    chk("drain_exp_q0_empty", exp_q0.size(), 0);
    chk("drain_exp_q1_empty", exp_q1.size(), 0);
  endtask

  // -------------------------------------------------------------------------
  // Directed scenarios followed by randomized traffic
  // -------------------------------------------------------------------------
  initial begin
    logic [RW-1:0] m;
    idle_inputs();
    #1;
    chk("reset_memreq_val", memreq_val, 0);
    chk("reset_memresp_rdy", memresp_rdy, 0);
    apply_reset();

    // Spurious response with nothing in flight: back-pressured
    memresp_val = 1'b1; in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
    #1;
    chk("spurious_memresp_rdy", memresp_rdy, 0);
    chk("spurious_resp_val", {in0_resp_val, in1_resp_val}, 0);
    cyc();
    idle_inputs();

    // 1: single request from in0, response 0xCAFE
    m = '0;
    m[65:34] = 32'h1000;
    in0_req_msg = m; in0_req_val = 1'b1; memreq_rdy = 1'b1;
    #1;
    chk("t1_in0_req_rdy", in0_req_rdy, 1);
    chk("t1_in1_req_rdy", in1_req_rdy, 0);
    chk("t1_memreq_msg", memreq_msg, m);
    cyc();
    in0_req_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = 45'hCAFE; in0_resp_rdy = 1'b1;
    #1;
    chk("t1_in0_resp_val", in0_resp_val, 1);
    chk("t1_in1_resp_val", in1_resp_val, 0);
    chk("t1_in0_resp_msg", in0_resp_msg, 45'hCAFE);
    cyc();
    memresp_val = 1'b0;

    // 2 + 3: alternating grants, fill to the limit, stall, release one
    apply_reset();
    in0_req_val = 1'b1; in1_req_val = 1'b1; memreq_rdy = 1'b1;
    in0_req_msg = 77'h100; in1_req_msg = 77'h200;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_grant0", in0_req_rdy, (i % 2) == 0);
      chk("t2_grant1", in1_req_rdy, (i % 2) == 1);
      cyc();
    end
    #1;
    chk("t3_stall_memreq_val", memreq_val, 0);
    chk("t3_stall_req_rdy", {in0_req_rdy, in1_req_rdy}, 0);
    memresp_val = 1'b1; memresp_msg = 45'h111; in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
    #1;
    chk("t3_release_in0_resp_val", in0_resp_val, 1);
    chk("t3_release_in1_resp_val", in1_resp_val, 0);
    cyc();
    memresp_val = 1'b0;
    #1;
    chk("t3_reissue_memreq_val", memreq_val, 1);
    chk("t3_reissue_in0_req_rdy", in0_req_rdy, 1);
    cyc();
    in0_req_val = 1'b0; in1_req_val = 1'b0;
    memresp_val = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("t2_route_in1", in1_resp_val, (i % 2) == 0);
      chk("t2_route_in0", in0_resp_val, (i % 2) == 1);
      cyc();
    end
    memresp_val = 1'b0;

    // 4: simultaneous push/pop at count 2 across pointer wrap
    apply_reset();
    in0_req_val = 1'b1; in1_req_val = 1'b1; memreq_rdy = 1'b1;
    in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
    repeat (2) cyc();
    memresp_val = 1'b1; memresp_msg = 45'h4444;
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t4_memreq_val", memreq_val, 1);
      chk("t4_memresp_rdy", memresp_rdy, 1);
      chk("t4_route_in0", in0_resp_val, (i % 2) == 0);
      cyc();
    end
    in0_req_val = 1'b0; in1_req_val = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("t4_drain_rdy", memresp_rdy, 1);
      cyc();
    end
    #1;
    chk("t4_empty_rdy", memresp_rdy, 0);
    memresp_val = 1'b0;

    // 5: head requester not ready holds the FIFO
    apply_reset();
    in1_req_val = 1'b1; memreq_rdy = 1'b1;
    cyc();
    in1_req_val = 1'b0;
    memresp_val = 1'b1; memresp_msg = 45'h5555; in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b0;
    #1;
    chk("t5_hold_memresp_rdy", memresp_rdy, 0);
    chk("t5_hold_in1_resp_val", in1_resp_val, 1);
    chk("t5_hold_in0_resp_val", in0_resp_val, 0);
    cyc();
    #1;
    chk("t5_hold2_memresp_rdy", memresp_rdy, 0);
    in1_resp_rdy = 1'b1;
    #1;
    chk("t5_go_memresp_rdy", memresp_rdy, 1);
    chk("t5_go_in1_resp_val", in1_resp_val, 1);
    chk("t5_go_in0_resp_val", in0_resp_val, 0);
    cyc();
    memresp_val = 1'b0;

    // 6: asynchronous reset with three requests outstanding
    apply_reset();
    in0_req_val = 1'b1; memreq_rdy = 1'b1;
    repeat (3) cyc();
    in1_req_val = 1'b1; memresp_val = 1'b1; in0_resp_rdy = 1'b1; in1_resp_rdy = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk("t6_async_memreq_val", memreq_val, 0);
    chk("t6_async_memresp_rdy", memresp_rdy, 0);
    chk("t6_async_req_rdy", {in0_req_rdy, in1_req_rdy}, 0);
    chk("t6_async_resp_val", {in0_resp_val, in1_resp_val}, 0);
    repeat (2) cyc();
    reset = 1'b1;
    #1;
    chk("t6_post_in0_req_rdy", in0_req_rdy, 1);
    chk("t6_post_in1_req_rdy", in1_req_rdy, 0);
    chk("t6_post_memresp_rdy", memresp_rdy, 0);
    chk("t6_post_resp_val", {in0_resp_val, in1_resp_val}, 0);
    cyc();
    idle_inputs();

    // Randomized traffic against the behavioural memory
    apply_reset();
    auto_mode = 1'b1;
    random_cycles(3000);
    drain();
    auto_mode = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
